// File: rtl/aes_iter_enc_pkg.sv
// Shared AES constants and helpers: S-box, Rcon, GF(2^8) doubling, SubWord,
// the core FSM state type and the NK -> NR mapping.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEYX = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } aes_state_e;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry j holds Rcon[j+1]; the schedule never needs Rcon[0].
    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic int nr_for_nk(input int nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/aes_iter_enc_if.sv
// Block-in / ciphertext-out handshake bundle of the iterative AES core.
// Vectors use FIPS-197 order: bit 0 is the MSB, byte 0 is [0:7].
interface aes_iter_enc_if #(
    parameter int NK = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic [0:127]      in;
    logic [0:32*NK-1]  key;
    logic              out_valid;
    logic              out_ready;
    logic [0:127]      out;

    modport master (
        output in_valid, in, key, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in, key, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/aes_iter_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns (skipped when final_round) and AddRoundKey.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic [127:0] next_state
);
    logic [127:0] sub_s;
    logic [127:0] shift_s;
    logic [127:0] mix_s;

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte b sits at [127-8b -: 8]; column c holds bytes 4c..4c+3, row = b mod 4.
    always_comb begin
        sub_s   = '0;
        shift_s = '0;
        mix_s   = '0;
        for (int b = 0; b < 16; b++) begin
            sub_s[127 - 8*b -: 8] = sbox(state[127 - 8*b -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_s[127 - 8*(4*c + r) -: 8] = sub_s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix_s[127 - 32*c -: 32] = mix_column(shift_s[127 - 32*c -: 32]);
        end
        if (final_round) begin
            next_state = shift_s ^ round_key;
        end else begin
            next_state = mix_s ^ round_key;
        end
    end
endmodule

// File: rtl/aes_iter_enc.sv
// Iterative AES-128/192/256 encryptor: on-the-fly key expansion (one word per
// cycle) then one round per cycle. Optional key cache: define AES_KEY_CACHE_EN.
module aes_iter_enc
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    aes_iter_enc_if.slave bus
);
    localparam int         NR          = nr_for_nk(NK);
    localparam int         NW          = 4 * (NR + 1);
    localparam logic [3:0] NR_L        = 4'(NR);
    localparam logic [5:0] NK_L        = 6'(NK);
    localparam logic [5:0] LAST_L      = 6'(NW - 1);
    localparam logic [2:0] KMOD_LAST_L = 3'(NK - 1);

    generate
        if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
            $error("aes_iter_enc: NK must be 4, 6 or 8");
        end
    endgenerate

    aes_state_e       fsm_r;
    logic [127:0]     blk_r;
    logic [127:0]     out_r;
    logic [31:0]      w_r [0:NW-1];
    logic [5:0]       i_r;
    logic [2:0]       kmod_r;
    logic [3:0]       rcon_idx_r;
    logic [3:0]       r_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [32*NK-1:0] key_s;
    logic [31:0]      key_word_s [0:NK-1];
    logic [31:0]      prev_w_s;
    logic [31:0]      new_w_s;
    logic [127:0]     rk_s;
    logic [127:0]     round_s;
    logic [127:0]     run_next_s;
    logic             accept_s;
    logic             key_hit_s;

    assign key_s    = bus.key;
    assign accept_s = (fsm_r == ST_IDLE) && bus.in_valid;

    // Split the flat key into schedule words, word 0 being the leading bytes.
    always_comb begin
        for (int j = 0; j < NK; j++) begin
            key_word_s[j] = key_s[32*(NK-1-j) +: 32];
        end
    end

`ifdef AES_KEY_CACHE_EN
    logic             cache_vld_r;
    logic [32*NK-1:0] stored_key_s;

    // The first NK schedule words are the stored key itself; compare against them.
    always_comb begin
        stored_key_s = '0;
        for (int j = 0; j < NK; j++) begin
            stored_key_s[32*(NK-1-j) +: 32] = w_r[j];
        end
        key_hit_s = cache_vld_r && (stored_key_s == key_s);
    end
`else
    assign key_hit_s = 1'b0;
`endif

    // Next key-schedule word w[i] from w[i-1] and w[i-NK].
    always_comb begin
        prev_w_s = w_r[i_r - 6'd1];
        if (kmod_r == 3'd0) begin
            new_w_s = sub_word({prev_w_s[23:0], prev_w_s[31:24]}) ^ {RCON[rcon_idx_r], 24'h000000};
        end else if ((NK == 8) && (kmod_r == 3'd4)) begin
            new_w_s = sub_word(prev_w_s);
        end else begin
            new_w_s = prev_w_s;
        end
        new_w_s = new_w_s ^ w_r[i_r - NK_L];
    end

    assign rk_s = {w_r[{r_r, 2'b00}], w_r[{r_r, 2'b01}], w_r[{r_r, 2'b10}], w_r[{r_r, 2'b11}]};

    aes_enc_round u_round (
        .state       (blk_r),
        .round_key   (rk_s),
        .final_round (r_r == NR_L),
        .next_state  (round_s)
    );

    // Step 0 is only the initial key whitening.
    always_comb begin
        if (r_r == 4'd0) begin
            run_next_s = blk_r ^ rk_s;
        end else begin
            run_next_s = round_s;
        end
    end

    // Round-key store: key words at accept, then one expanded word per KEYX cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NW; j++) begin
                w_r[j] <= 32'h00000000;
            end
        end else if (accept_s) begin
            for (int j = 0; j < NK; j++) begin
                w_r[j] <= key_word_s[j];
            end
        end else if (fsm_r == ST_KEYX) begin
            w_r[i_r] <= new_w_s;
        end
    end

    // Control FSM with registered handshake outputs and round datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= ST_IDLE;
            blk_r       <= 128'h0;
            out_r       <= 128'h0;
            i_r         <= 6'd0;
            kmod_r      <= 3'd0;
            rcon_idx_r  <= 4'd0;
            r_r         <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef AES_KEY_CACHE_EN
            cache_vld_r <= 1'b0;
`endif
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        blk_r      <= bus.in;
                        in_ready_r <= 1'b0;
                        r_r        <= 4'd0;
                        if (key_hit_s) begin
                            fsm_r <= ST_RUN;
                        end else begin
                            fsm_r      <= ST_KEYX;
                            i_r        <= NK_L;
                            kmod_r     <= 3'd0;
                            rcon_idx_r <= 4'd0;
`ifdef AES_KEY_CACHE_EN
                            cache_vld_r <= 1'b0;
`endif
                        end
                    end
                end
                ST_KEYX: begin
                    i_r <= i_r + 6'd1;
                    if (kmod_r == KMOD_LAST_L) begin
                        kmod_r <= 3'd0;
                    end else begin
                        kmod_r <= kmod_r + 3'd1;
                    end
                    if (kmod_r == 3'd0) begin
                        rcon_idx_r <= rcon_idx_r + 4'd1;
                    end
                    if (i_r == LAST_L) begin
                        fsm_r <= ST_RUN;
                        r_r   <= 4'd0;
`ifdef AES_KEY_CACHE_EN
                        cache_vld_r <= 1'b1;
`endif
                    end
                end
                ST_RUN: begin
                    blk_r <= run_next_s;
                    if (r_r == NR_L) begin
                        fsm_r       <= ST_DONE;
                        out_r       <= run_next_s;
                        out_valid_r <= 1'b1;
                        r_r         <= 4'd0;
                    end else begin
                        r_r <= r_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        fsm_r       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    fsm_r       <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    r_r         <= 4'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
endmodule
